// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined WIDTH-bit bitwise logic unit.
//               Per-transaction op select (AND/OR/NOT/NAND/NOR/XOR/XNOR),
//               valid/ready on both sides, 2-cycle latency, full throughput.
//               Op 7 is illegal: result passes operand a through and the
//               sticky err flag is raised.
// Config      : define LOGIC_UNIT_REDUCE_EN to add registered y_all/y_any/y_par.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef LOGIC_UNIT_REDUCE_EN
    output logic             y_all,
    output logic             y_any,
    output logic             y_par,
`endif
    output logic             err,
    input  logic             err_clr
);

    localparam logic [2:0] c_OP_AND     = 3'd0;
    localparam logic [2:0] c_OP_OR      = 3'd1;
    localparam logic [2:0] c_OP_NOT     = 3'd2;
    localparam logic [2:0] c_OP_NAND    = 3'd3;
    localparam logic [2:0] c_OP_NOR     = 3'd4;
    localparam logic [2:0] c_OP_XOR     = 3'd5;
    localparam logic [2:0] c_OP_XNOR    = 3'd6;
    localparam logic [2:0] c_OP_ILLEGAL = 3'd7;

    // Stage 1: captured operands
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_y;
    logic             r_err;

    logic             w_s2_ready;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_result;

    // Ready chain is purely combinational so a full pipe can drain, shift and
    // accept in the same edge without a bubble.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_s1_valid && w_s2_ready;

    // Stage 1 register: load on acceptance, empty when handed to stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op;
            r_s1_a     <= a;
            r_s1_b     <= b;
        end else if (w_xfer) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Bitwise function of the stage 1 contents; illegal op passes a through
    always_comb begin
        w_result = r_s1_a;
        case (r_s1_op)
            c_OP_AND:  w_result = r_s1_a & r_s1_b;
            c_OP_OR:   w_result = r_s1_a | r_s1_b;
            c_OP_NOT:  w_result = ~r_s1_a;
            c_OP_NAND: w_result = ~(r_s1_a & r_s1_b);
            c_OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
            c_OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            c_OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
            default:   w_result = r_s1_a;
        endcase
    end

    // Stage 2 register: load on transfer, empty on consumption; data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
        end else if (w_xfer) begin
            r_s2_valid <= 1'b1;
            r_s2_y     <= w_result;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Sticky error: a new illegal acceptance takes priority over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (op == c_OP_ILLEGAL)) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    logic r_s2_all;
    logic r_s2_any;
    logic r_s2_par;

    // Reduction flags travel in stage 2 alongside the result they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_all <= 1'b0;
            r_s2_any <= 1'b0;
            r_s2_par <= 1'b0;
        end else if (w_xfer) begin
            r_s2_all <= &w_result;
            r_s2_any <= |w_result;
            r_s2_par <= ^w_result;
        end
    end

    assign y_all = r_s2_all;
    assign y_any = r_s2_any;
    assign y_par = r_s2_par;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign y         = r_s2_y;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe (WIDTH=8). Directed
//               scenarios plus a randomized run against a transaction-level
//               scoreboard. Reduction flags are checked when
//               LOGIC_UNIT_REDUCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic             y_all;
    logic             y_any;
    logic             y_par;
`endif
    logic             err;
    logic             err_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Scoreboard entry: expected result and the edge index at which it was accepted
    typedef struct {
        logic [WIDTH-1:0] y;
        int               acc_cyc;
    } txn_t;

    txn_t sb[$];
    logic err_exp;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef LOGIC_UNIT_REDUCE_EN
        .y_all     (y_all),
        .y_any     (y_any),
        .y_par     (y_par),
`endif
        .err       (err),
        .err_clr   (err_clr)
    );

    // Reference behaviour of one transaction
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        case (f)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~x;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return x ^ z;
            3'd6:    return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    // Advance one clock edge; drive inputs shortly after it
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", y); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef LOGIC_UNIT_REDUCE_EN
        n_tests++; if ({y_all, y_any, y_par} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {y_all, y_any, y_par}); end
`endif
    endtask

    task automatic test_op_stream();
        logic [WIDTH-1:0] exp_y [7];
        exp_y = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00};
        for (int c = 0; c < 9; c++) begin
            tick();
            out_ready = 1'b1;
            if (c < 7) begin
                in_valid = 1'b1; op = 3'(c); a = 8'hC5; b = 8'h3A;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 7) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, in_ready); end
            end
            if (c >= 2) begin
                n_tests++; if (out_valid !== 1'b1 || y !== exp_y[c-2]) begin
                    n_fail++; $display("FAIL stream_op%0d: got valid=%b y=%h want valid=1 y=%h", c-2, out_valid, y, exp_y[c-2]);
                end
            end else begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency[%0d]: got valid=%b want 0", c, out_valid); end
            end
        end
        tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got valid=%b want 0", out_valid); end
    endtask

`ifdef LOGIC_UNIT_REDUCE_EN
    task automatic test_reduce();
        tick();
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h0F;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || y !== 8'h0F) begin n_fail++; $display("FAIL reduce_y: got valid=%b y=%h want valid=1 y=0f", out_valid, y); end
        n_tests++; if ({y_all, y_any, y_par} !== 3'b010) begin n_fail++; $display("FAIL reduce_flags: got %b want 010", {y_all, y_any, y_par}); end
        tick();
    endtask
`endif

    task automatic test_backpressure();
        logic [2:0]       bop [3];
        logic [WIDTH-1:0] ba [3];
        logic [WIDTH-1:0] bb [3];
        logic [WIDTH-1:0] bexp [3];
        for (int i = 0; i < 3; i++) begin
            bop[i] = 3'($urandom_range(0, 6));
            ba[i]  = 8'($urandom);
            bb[i]  = 8'($urandom);
            bexp[i] = ref_op(bop[i], ba[i], bb[i]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            out_ready = 1'b0; in_valid = 1'b1; op = bop[i]; a = ba[i]; b = bb[i];
            @(negedge clk);
            n_tests++; if (in_ready !== (i < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, in_ready, (i < 2)); end
        end
        n_tests++; if (out_valid !== 1'b1 || y !== bexp[0]) begin n_fail++; $display("FAIL bp_full_head: got valid=%b y=%h want valid=1 y=%h", out_valid, y, bexp[0]); end
        tick();
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b0 || y !== bexp[0]) begin n_fail++; $display("FAIL bp_hold: got ready=%b y=%h want ready=0 y=%h", in_ready, y, bexp[0]); end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        for (int i = 1; i < 3; i++) begin
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b1 || y !== bexp[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got valid=%b y=%h want valid=1 y=%h", i, out_valid, y, bexp[i]); end
        end
        tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got valid=%b want 0", out_valid); end
    endtask

    // One randomized cycle against the scoreboard; drain forces a quiet, ready consumer
    task automatic rand_step(input bit drain);
        logic exp_ov;
        logic exp_ir;
        tick();
        if (drain) begin
            in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        end else begin
            in_valid  = 1'($urandom_range(0, 1));
            op        = 3'($urandom_range(0, 7));
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        // A transaction is visible from the edge after its acceptance until consumed
        exp_ov = (sb.size() > 0) && (sb[0].acc_cyc < cyc);
        exp_ir = (sb.size() < 2) || out_ready;
        n_tests++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b want %b", cyc, in_ready, exp_ir); end
        n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b want %b", cyc, out_valid, exp_ov); end
        n_tests++; if (err !== err_exp) begin n_fail++; $display("FAIL rand_err@%0d: got %b want %b", cyc, err, err_exp); end
        if (exp_ov) begin
            n_tests++; if (y !== sb[0].y) begin n_fail++; $display("FAIL rand_y@%0d: got %h want %h", cyc, y, sb[0].y); end
`ifdef LOGIC_UNIT_REDUCE_EN
            n_tests++; if ({y_all, y_any, y_par} !== {&sb[0].y, |sb[0].y, ^sb[0].y}) begin
                n_fail++; $display("FAIL rand_flags@%0d: got %b want %b", cyc, {y_all, y_any, y_par}, {&sb[0].y, |sb[0].y, ^sb[0].y});
            end
`endif
            if (out_ready) void'(sb.pop_front());
        end
        if (in_valid && exp_ir) sb.push_back('{y: ref_op(op, a, b), acc_cyc: cyc + 1});
        if (in_valid && exp_ir && op == 3'd7) err_exp = 1'b1;
        else if (err_clr)                     err_exp = 1'b0;
    endtask

    task automatic test_random();
        sb.delete();
        err_exp = 1'b0;
        for (int i = 0; i < 400; i++) rand_step(1'b0);
        for (int i = 0; i < 6; i++) rand_step(1'b1);
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_illegal();
        tick();
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'h5A; b = 8'($urandom);
        @(negedge clk);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_pre: got %b want 0", err); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %b want 1", err); end
        tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || y !== 8'h5A) begin n_fail++; $display("FAIL ill_pass: got valid=%b y=%h want valid=1 y=5a", out_valid, y); end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clr: got %b want 0", err); end
        tick();
        in_valid = 1'b1; op = 3'd7; a = 8'($urandom);
        tick();
        err_clr = 1'b1;
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_reset: got %b want 1", err); end
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_set_wins: got %b want 1", err); end
        repeat (3) tick();
    endtask

    task automatic test_reset_midflight();
        logic [WIDTH-1:0] na;
        logic [WIDTH-1:0] nb;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; a = 8'($urandom);
        tick();
        op = 3'd1; a = 8'($urandom); b = 8'($urandom);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_full: got valid=%b ready=%b err=%b want 1 0 1", out_valid, in_ready, err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_async_err: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        na = 8'($urandom); nb = 8'($urandom);
        tick();
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; a = na; b = nb;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_post_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_early: got valid=%b want 0", out_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || y !== (na ^ nb)) begin
            n_fail++; $display("FAIL rst_post_result: got valid=%b y=%h want valid=1 y=%h", out_valid, y, na ^ nb);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_op_stream();
`ifdef LOGIC_UNIT_REDUCE_EN
        test_reduce();
`endif
        test_backpressure();
        test_random();
        test_illegal();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
